// File: rtl/mul_add_tree.sv
// rtl/mul_add_tree.sv - unsigned WIDTH x WIDTH multiplier as a pipelined adder tree of shifted partial products
//
// Optional build macro: MUL_ADD_TREE_PIPE_EN
//   undefined : tree is combinational from the pins, only the product is registered (latency 1)
//   defined   : first tree level (pair sums plus pass-through) is also registered (latency 2)

module mul_add_tree #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   mul_out
);

  localparam int PW = 2 * WIDTH;        // product width
  localparam int N1 = (WIDTH + 1) / 2;  // terms after the first tree level

  logic [PW-1:0] pp      [WIDTH];
  logic [PW-1:0] lvl1    [N1];
  logic [PW-1:0] tree_in [N1];
  logic          tree_vld;
  logic [PW-1:0] tree_sum;

  logic [PW-1:0] prod_q, prod_d;
  logic          vld_q,  vld_d;

  // Partial products and the first level of pairwise sums (odd term passes through)
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = mul_b[i] ? ({{WIDTH{1'b0}}, mul_a} << i) : '0;
    end
    for (int i = 0; i < N1; i++) begin
      if (2 * i + 1 < WIDTH) begin
        lvl1[i] = pp[2*i] + pp[2*i+1];
      end else begin
        lvl1[i] = pp[2*i];
      end
    end
  end

`ifdef MUL_ADD_TREE_PIPE_EN
  logic [PW-1:0] s1_q [N1];
  logic [PW-1:0] s1_d [N1];
  logic          s1_vld_q, s1_vld_d;

  // Level-1 bank loads only on a valid input so idle operands never enter the tree
  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = in_valid;
    if (in_valid) begin
      s1_d = lvl1;
    end
  end

  // Level-1 register bank and its valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N1; i++) begin
        s1_q[i] <= '0;
      end
      s1_vld_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
    end
  end

  // Remaining tree levels are fed from the registered level-1 terms
  always_comb begin
    tree_in  = s1_q;
    tree_vld = s1_vld_q;
  end
`else
  // Remaining tree levels are fed straight from the combinational level-1 terms
  always_comb begin
    tree_in  = lvl1;
    tree_vld = in_valid;
  end
`endif

  // Reduce the level-1 terms pairwise, level by level, until one sum is left
  always_comb begin
    logic [PW-1:0] tmp [N1];
    int            n;
    int            ia;
    int            ib;
    tmp = tree_in;
    n   = N1;
    for (int lv = 0; lv < 4; lv++) begin
      for (int j = 0; j < N1; j++) begin
        ia = (2 * j     <= N1 - 1) ? 2 * j     : N1 - 1;
        ib = (2 * j + 1 <= N1 - 1) ? 2 * j + 1 : N1 - 1;
        if (j < (n + 1) / 2) begin
          if (2 * j + 1 < n) begin
            tmp[j] = tmp[ia] + tmp[ib];
          end else begin
            tmp[j] = tmp[ia];
          end
        end
      end
      n = (n + 1) / 2;
    end
    tree_sum = tmp[0];
  end

  // Output stage holds the last product while idle; valid follows the load strobe
  always_comb begin
    prod_d = prod_q;
    vld_d  = tree_vld;
    if (tree_vld) begin
      prod_d = tree_sum;
    end
  end

  // Output register; reset has priority over any incoming operands
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

  assign mul_out   = prod_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mul_add_tree.sv
// tb/tb_mul_add_tree.sv - scoreboard bench for mul_add_tree (default and MUL_ADD_TREE_PIPE_EN builds)

module tb_mul_add_tree;

`ifdef MUL_ADD_TREE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       out_valid;
  logic [7:0] mul_out;

  mul_add_tree #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .out_valid (out_valid),
    .mul_out   (mul_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         due;
  } sb_t;

  vec_t       vecs [15];
  sb_t        sbq [$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic [7:0] last_prod;
  logic [7:0] cur_exp;

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    last_prod = 8'h00;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output check against the scoreboard, then record what the next edge will sample
  always @(negedge clk) begin
    sb_t e;
    logic exp_v;
    exp_v = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e         = sbq.pop_front();
      last_prod = e.exp;
      exp_v     = 1'b1;
    end
    n_checks++;
    if (out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL out_valid cycle %0d: got %b expected %b", cyc, out_valid, exp_v);
    end
    n_checks++;
    if (mul_out !== last_prod) begin
      n_fail++;
      $display("FAIL mul_out cycle %0d: got %0d expected %0d", cyc, mul_out, last_prod);
    end
    if (rst) begin
      sbq.delete();
      last_prod = 8'h00;
    end else if (in_valid) begin
      e.exp = cur_exp;
      e.due = cyc + LAT;
      sbq.push_back(e);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp);
    rst      = r;
    in_valid = v;
    mul_a    = a;
    mul_b    = b;
    cur_exp  = exp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0, 4'd0, 8'd0};
    vecs[1]  = '{4'd1, 4'd1, 8'd1};
    vecs[2]  = '{4'd2, 4'd2, 8'd4};
    vecs[3]  = '{4'd3, 4'd3, 8'd9};
    vecs[4]  = '{4'd4, 4'd4, 8'd16};
    vecs[5]  = '{4'd5, 4'd5, 8'd25};
    vecs[6]  = '{4'd6, 4'd6, 8'd36};
    vecs[7]  = '{4'd7, 4'd7, 8'd49};
    vecs[8]  = '{4'd8, 4'd8, 8'd64};
    vecs[9]  = '{4'd9, 4'd9, 8'h51};
    vecs[10] = '{4'd15, 4'd15, 8'hE1};
    vecs[11] = '{4'd15, 4'd0, 8'd0};
    vecs[12] = '{4'd0, 4'd15, 8'd0};
    vecs[13] = '{4'd1, 4'd15, 8'd15};
    vecs[14] = '{4'd8, 4'd8, 8'd64};

    // Reset held with valid operands present: nothing may emerge
    drive(1'b1, 1'b1, 4'd7, 4'd9, 8'd63);
    drive(1'b1, 1'b1, 4'd7, 4'd9, 8'd63);
    idle(4);

    // Ramp and extremes, back to back
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    idle(3);

    // Idle hold after 6*7
    drive(1'b0, 1'b1, 4'd6, 4'd7, 8'd42);
    idle(3);
    n_checks++;
    if (mul_out !== 8'd42) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d expected 42", mul_out);
    end

    // Mid-stream reset: third operand pair arrives together with reset
    drive(1'b0, 1'b1, 4'd3, 4'd5, 8'd15);
    drive(1'b0, 1'b1, 4'd4, 4'd4, 8'd16);
    drive(1'b1, 1'b1, 4'd2, 4'd9, 8'd18);
    n_checks++;
    if (mul_out !== 8'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%0d valid=%b expected out=0 valid=0", mul_out, out_valid);
    end
    idle(2);
    drive(1'b0, 1'b1, 4'd5, 4'd5, 8'd25);
    idle(LAT);
    n_checks++;
    if (mul_out !== 8'd25) begin
      n_fail++;
      $display("FAIL post_reset: got %0d expected 25", mul_out);
    end
    idle(2);

    // Exhaustive operand sweep, one pair per cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(1'b0, 1'b1, 4'(a), 4'(b), 8'(a * b));
      end
    end
    idle(LAT + 3);

    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d products still pending, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_add_tree.md
Name: mul_add_tree

Overview:
- Unsigned WIDTH x WIDTH multiplier built as a binary adder tree of shifted partial products; default is 4x4 giving an 8-bit product.
- Pipelined and registered, one result per cycle, with a valid strobe alongside the data.
- Used as the arithmetic core behind the Tiny Tapeout wrapper pins: operands come from input pins, the product goes to the output pins.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands on mul_a/mul_b are valid this cycle
- mul_a  input  WIDTH  multiplicand, unsigned
- mul_b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  mul_out carries a new product this cycle
- mul_out  output  2*WIDTH  unsigned product mul_a*mul_b

Interface rules:
- One clock (clk).
- Reset (rst) is synchronous and active-high.
- No asynchronous logic.

Behaviour:
- Partial products:
  - pp[i] = mul_b[i] ? (mul_a zero-extended to 2*WIDTH) << i : 0, for i = 0..WIDTH-1.
- Adder tree:
  - Level k adds adjacent pairs from level k-1: pp0+pp1, pp2+pp3, ...
  - An odd leftover term passes through unchanged to the next level.
  - All sums are 2*WIDTH bits. No overflow is possible, since the max product is (2^WIDTH-1)^2.
  - For WIDTH=4: add01 = pp0+pp1, add23 = pp2+pp3, product = add01+add23.
- Sampling:
  - When in_valid=1 on a rising edge, the operands are sampled into the pipeline.
- Latency (default build):
  - The tree is combinational from the inputs; only the final sum is registered.
  - mul_out and out_valid appear 1 cycle after the sampling edge.
- out_valid:
  - Equals in_valid delayed by the pipeline latency.
  - Throughput is 1 product per cycle with no stalls and no back-pressure.
- Idle cycles:
  - When in_valid=0, the pipeline stage does not load.
  - mul_out holds its last product and out_valid=0 for the corresponding cycle.
- Reset:
  - On any clock edge with rst=1: mul_out=0, out_valid=0, and all internal pipeline registers and valid bits clear.
  - In-flight operands are discarded, even if reset arrives mid-operation.
  - The first valid output after reset deasserts corresponds to the first in_valid sampled with rst=0.
- Simultaneous rst=1 and in_valid=1: reset wins; the operands are dropped.
- Boundaries:
  - Either operand 0 gives product 0.
  - Max operands (15x15 for WIDTH=4) give 225 = 8'hE1 with no wrap.
- Ignored inputs:
  - X/Z on mul_a/mul_b while in_valid=0 must not propagate to mul_out.

Optional Feature:
- Macro: MUL_ADD_TREE_PIPE_EN.
- Defined:
  - An extra register bank after the first tree level (the pairwise sums plus any pass-through term) and its valid bit.
  - Latency becomes 2 cycles; throughput is still 1 per cycle.
  - Reset clears the extra stage too.
  - Idle behaviour and reset priority are the same as the default build.
- Not defined: single-register implementation with 1-cycle latency as described above.
- Functional results are identical in both builds; only the latency differs.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1, a=7, b=9 -> mul_out=0 and out_valid=0 throughout, and no product emerges after rst deasserts.
- Ramp: a=b stepping 0..9, one pair every cycle with in_valid=1 -> mul_out sequence 0,1,4,9,16,25,36,49,64,81 (8'h51), each with out_valid=1 exactly LAT cycles after input (LAT=1, or 2 with MUL_ADD_TREE_PIPE_EN).
- Extremes: (15,15)->225, (15,0)->0, (0,15)->0, (1,15)->15, (8,8)->64, each checked at latency LAT.
- Idle hold: product (6,7)=42, then in_valid=0 for 3 cycles with random operands -> mul_out stays 42 and out_valid=0.
- Mid-stream reset: stream (3,5),(4,4),(2,9) and pulse rst for one cycle after the 2nd input -> in-flight results are discarded, mul_out=0 and out_valid=0, and the next valid input (5,5) yields 25.
- Exhaustive: all 256 operand pairs back-to-back -> every mul_out equals a*b, and out_valid stays continuously high after the initial latency.
